// File: rtl/dcache_if.sv
// LSU and memory-side signal bundle for the direct-mapped data cache.
// The slave modport is the cache's view; master is the surrounding LSU/memory environment.
interface dcache_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_DATA_WIDTH = 4
);
    logic                       data_req;
    logic [DATA_WIDTH-1:0]      data_addr;
    logic                       data_we;
    logic [DATA_WIDTH-1:0]      wdata;
    logic [BYTE_DATA_WIDTH-1:0] byte_enable;
    logic [DATA_WIDTH-1:0]      rdata;
    logic                       data_valid;
    logic                       flush;

    logic                       mem_req;
    logic                       mem_we;
    logic [DATA_WIDTH-1:0]      mem_addr;
    logic [DATA_WIDTH-1:0]      mem_wdata;
    logic [BYTE_DATA_WIDTH-1:0] mem_be;
    logic [DATA_WIDTH-1:0]      mem_rdata;
    logic                       mem_ack;

    modport slave (
        input  data_req, data_addr, data_we, wdata, byte_enable, flush,
        input  mem_rdata, mem_ack,
        output rdata, data_valid,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output data_req, data_addr, data_we, wdata, byte_enable, flush,
        output mem_rdata, mem_ack,
        input  rdata, data_valid,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// All outputs are registered; the controller is a four-state FSM (IDLE/FILL/WRITE/RESP).
module dcache #(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_DATA_WIDTH = 4,
    parameter int INDEX_WIDTH     = 4
) (
    input logic     clk,
    input logic     rst,
    dcache_if.slave bus
);
    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = DATA_WIDTH - INDEX_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]           valid_q, valid_d;
    logic [TAG_WIDTH-1:0]       tag_q  [LINES];
    logic [DATA_WIDTH-1:0]      line_q [LINES];

    logic                       data_valid_q, data_valid_d;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic                       mem_req_q, mem_req_d;
    logic                       mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
    logic [BYTE_DATA_WIDTH-1:0] mem_be_q, mem_be_d;

    logic [INDEX_WIDTH-1:0]     req_idx, mem_idx;
    logic [TAG_WIDTH-1:0]       req_tag, mem_tag;
    logic                       req_hit, mem_hit;
    logic [DATA_WIDTH-1:0]      merged_data;
    logic                       line_we;
    logic [DATA_WIDTH-1:0]      line_wdata;

    // Lookups: the incoming request in IDLE, and the latched memory address while an access is in flight.
    always_comb begin
        req_idx     = bus.data_addr[INDEX_WIDTH+1:2];
        req_tag     = bus.data_addr[DATA_WIDTH-1:INDEX_WIDTH+2];
        req_hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
        mem_idx     = mem_addr_q[INDEX_WIDTH+1:2];
        mem_tag     = mem_addr_q[DATA_WIDTH-1:INDEX_WIDTH+2];
        mem_hit     = valid_q[mem_idx] && (tag_q[mem_idx] == mem_tag);
        merged_data = line_q[mem_idx];
        for (int unsigned i = 0; i < BYTE_DATA_WIDTH; i++) begin
            if (mem_be_q[i]) begin
                merged_data[8*i +: 8] = mem_wdata_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            data_valid_q <= 1'b0;
            rdata_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            data_valid_q <= data_valid_d;
            rdata_q      <= rdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
        end
    end

    // Tag and data arrays carry no reset; the rst gate keeps an abandoned access from updating a line.
    always_ff @(posedge clk) begin
        if (!rst && line_we) begin
            tag_q[mem_idx]  <= mem_tag;
            line_q[mem_idx] <= line_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.data_req) begin
                    if (bus.data_we) begin
                        state_d = WRITE;
                    end else if (req_hit) begin
                        state_d = RESP;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL:  if (bus.mem_ack) state_d = RESP;
            WRITE: if (bus.mem_ack) state_d = RESP;
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d      = valid_q;
        data_valid_d = 1'b0;
        rdata_d      = rdata_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        line_we      = 1'b0;
        line_wdata   = merged_data;
        unique case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    valid_d = '0;
                end else if (bus.data_req) begin
                    if (bus.data_we) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {bus.data_addr[DATA_WIDTH-1:2], 2'b00};
                        mem_wdata_d = bus.wdata;
                        mem_be_d    = bus.byte_enable;
                    end else if (req_hit) begin
                        data_valid_d = 1'b1;
                        rdata_d      = line_q[req_idx];
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {bus.data_addr[DATA_WIDTH-1:2], 2'b00};
                        mem_be_d   = '1;
                    end
                end
            end
            FILL: begin
                if (bus.mem_ack) begin
                    mem_req_d        = 1'b0;
                    data_valid_d     = 1'b1;
                    rdata_d          = bus.mem_rdata;
                    line_we          = 1'b1;
                    line_wdata       = bus.mem_rdata;
                    valid_d[mem_idx] = 1'b1;
                end
            end
            WRITE: begin
                if (bus.mem_ack) begin
                    mem_req_d    = 1'b0;
                    data_valid_d = 1'b1;
                    line_we      = mem_hit;
                end
            end
            RESP: begin
            end
            default: begin
            end
        endcase
    end

    assign bus.data_valid = data_valid_q;
    assign bus.rdata      = rdata_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_be     = mem_be_q;
endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed vector table, flush/reset corner sequences,
// then randomized traffic checked against a transaction-level cache and memory model.
module tb_dcache;
    logic clk;
    logic rst;

    dcache_if #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4)) bus ();

    dcache #(
        .DATA_WIDTH(32),
        .BYTE_DATA_WIDTH(4),
        .INDEX_WIDTH(4)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: backing memory plus which word address each cache slot holds.
    logic [31:0] mem [logic [31:0]];
    bit          mv [16];
    logic [31:0] ma [16];
    logic [31:0] last_load;

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [31:0] wd;
        logic [3:0]  be;
        int unsigned delay;
        bit          exp_miss;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h3C5A_96E1;
    endfunction

    task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] w;
        w = mem_rd(a);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) w[8*i +: 8] = d[8*i +: 8];
        end
        mem[a] = w;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    endtask

    // Drives one LSU request and plays the memory side with a given ack delay.
    task automatic access(input logic [31:0] addr, input bit we, input logic [31:0] wd,
                          input logic [3:0] be, input int unsigned delay,
                          output int unsigned lat, output int unsigned mcyc, output logic [31:0] rd);
        logic [31:0] wa;
        bit          done;
        int unsigned cyc;
        wa  = {addr[31:2], 2'b00};
        bus.data_addr   = addr;
        bus.data_we     = we;
        bus.wdata       = wd;
        bus.byte_enable = be;
        bus.data_req    = 1'b1;
        lat  = 0;
        mcyc = 0;
        rd   = '0;
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
            if (bus.data_valid) begin
                done = 1'b1;
                lat  = cyc;
                rd   = bus.rdata;
                bus.data_req = 1'b0;
                chk("resp_mem_req_low", {31'b0, bus.mem_req}, 32'd0);
            end else if (bus.mem_req) begin
                mcyc++;
                chk("mem_addr", bus.mem_addr, wa);
                chk("mem_we", {31'b0, bus.mem_we}, {31'b0, we});
                chk("mem_be", {28'b0, bus.mem_be}, we ? {28'b0, be} : 32'h0000_000F);
                if (we) chk("mem_wdata", bus.mem_wdata, wd);
                if (mcyc == delay + 1) begin
                    bus.mem_ack = 1'b1;
                    if (we) mem_wr(wa, wd, be);
                    else    bus.mem_rdata = mem_rd(wa);
                end
            end
        end
        if (!done) begin
            chk("response_timeout", 32'd0, 32'd1);
            bus.data_req = 1'b0;
            bus.mem_ack  = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("valid_one_cycle", {31'b0, bus.data_valid}, 32'd0);
        chk("idle_mem_req", {31'b0, bus.mem_req}, 32'd0);
    endtask

    task automatic xact(input logic [31:0] addr, input bit we, input logic [31:0] wd,
                        input logic [3:0] be, input int unsigned delay,
                        output int unsigned lat, output int unsigned mcyc, output logic [31:0] rd,
                        output int unsigned e_lat, output int unsigned e_mcyc, output logic [31:0] e_rd);
        logic [31:0] wa;
        logic [3:0]  idx;
        bit          hit;
        wa     = {addr[31:2], 2'b00};
        idx    = addr[5:2];
        hit    = !we && mv[idx] && (ma[idx] == wa);
        e_rd   = we ? last_load : mem_rd(wa);
        e_mcyc = hit ? 0 : delay + 1;
        e_lat  = hit ? 1 : delay + 2;
        access(addr, we, wd, be, delay, lat, mcyc, rd);
        if (!we) begin
            mv[idx]   = 1'b1;
            ma[idx]   = wa;
            last_load = e_rd;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned lat, mcyc, e_lat, e_mcyc;
        logic [31:0] rd, e_rd;

        vecs[0]  = '{32'h0000_0040, 1'b0, 32'h0,          4'b0000, 2, 1'b1, 32'hDEAD_BEEF};
        vecs[1]  = '{32'h0000_0040, 1'b0, 32'h0,          4'b0000, 0, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{32'h0000_0040, 1'b1, 32'h1122_3344, 4'b0011, 1, 1'b1, 32'hDEAD_BEEF};
        vecs[3]  = '{32'h0000_0040, 1'b0, 32'h0,          4'b0000, 0, 1'b0, 32'hDEAD_3344};
        vecs[4]  = '{32'h0000_0080, 1'b1, 32'h1234_5678, 4'b1111, 0, 1'b1, 32'hDEAD_3344};
        vecs[5]  = '{32'h0000_0080, 1'b0, 32'h0,          4'b0000, 1, 1'b1, 32'h1234_5678};
        vecs[6]  = '{32'h0000_0440, 1'b0, 32'h0,          4'b0000, 0, 1'b1, 32'hCAFE_F00D};
        vecs[7]  = '{32'h0000_0040, 1'b0, 32'h0,          4'b0000, 3, 1'b1, 32'hDEAD_3344};
        vecs[8]  = '{32'h0000_0043, 1'b0, 32'h0,          4'b0000, 0, 1'b0, 32'hDEAD_3344};
        vecs[9]  = '{32'h0000_0040, 1'b1, 32'hFFFF_FFFF, 4'b0000, 0, 1'b1, 32'hDEAD_3344};
        vecs[10] = '{32'h0000_0040, 1'b0, 32'h0,          4'b0000, 0, 1'b0, 32'hDEAD_3344};

        mem[32'h0000_0040] = 32'hDEAD_BEEF;
        mem[32'h0000_0440] = 32'hCAFE_F00D;
        model_clear();
        last_load = '0;

        bus.data_req    = 1'b0;
        bus.data_addr   = '0;
        bus.data_we     = 1'b0;
        bus.wdata       = '0;
        bus.byte_enable = '0;
        bus.flush       = 1'b0;
        bus.mem_rdata   = '0;
        bus.mem_ack     = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_valid", {31'b0, bus.data_valid}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mem_be", {28'b0, bus.mem_be}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 11; v++) begin
            xact(vecs[v].addr, vecs[v].we, vecs[v].wd, vecs[v].be, vecs[v].delay,
                 lat, mcyc, rd, e_lat, e_mcyc, e_rd);
            chk($sformatf("vec%0d_latency", v), lat, vecs[v].exp_miss ? vecs[v].delay + 2 : 1);
            chk($sformatf("vec%0d_mem_cycles", v), mcyc, vecs[v].exp_miss ? vecs[v].delay + 1 : 0);
            chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rd);
        end

        // Flush together with a request on a cached line: request waits a cycle, then misses.
        bus.data_addr = 32'h0000_0040;
        bus.data_we   = 1'b0;
        bus.data_req  = 1'b1;
        bus.flush     = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_no_valid", {31'b0, bus.data_valid}, 32'd0);
        chk("flush_no_mem_req", {31'b0, bus.mem_req}, 32'd0);
        model_clear();
        xact(32'h0000_0040, 1'b0, 32'h0, 4'b0, 0, lat, mcyc, rd, e_lat, e_mcyc, e_rd);
        chk("flush_miss_mem_cycles", mcyc, 32'd1);
        chk("flush_miss_latency", lat, 32'd2);
        chk("flush_miss_rdata", rd, 32'hDEAD_3344);

        // Reset in the second FILL cycle abandons the refill; a late ack is ignored.
        bus.data_addr = 32'h0000_0140;
        bus.data_we   = 1'b0;
        bus.data_req  = 1'b1;
        @(posedge clk);
        #1;
        chk("rstfill_req_up", {31'b0, bus.mem_req}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.data_req = 1'b0;
        chk("rstfill_mem_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rstfill_valid", {31'b0, bus.data_valid}, 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        chk("late_ack_valid", {31'b0, bus.data_valid}, 32'd0);
        chk("late_ack_mem_req", {31'b0, bus.mem_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("late_ack_valid2", {31'b0, bus.data_valid}, 32'd0);
        chk("rstfill_rdata", bus.rdata, 32'd0);
        model_clear();
        last_load = '0;
        xact(32'h0000_0140, 1'b0, 32'h0, 4'b0, 1, lat, mcyc, rd, e_lat, e_mcyc, e_rd);
        chk("rstfill_reload_mem_cycles", mcyc, 32'd2);
        chk("rstfill_reload_rdata", rd, mem_rd(32'h0000_0140));

        for (int n = 0; n < 150; n++) begin
            logic [31:0] addr;
            bit          we;
            if ($urandom_range(0, 19) == 0) begin
                bus.flush = 1'b1;
                @(posedge clk);
                #1;
                bus.flush = 1'b0;
                model_clear();
                chk("rand_flush_valid", {31'b0, bus.data_valid}, 32'd0);
            end
            addr = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            we   = ($urandom_range(0, 9) < 3);
            xact(addr, we, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 lat, mcyc, rd, e_lat, e_mcyc, e_rd);
            chk($sformatf("rand%0d_latency", n), lat, e_lat);
            chk($sformatf("rand%0d_mem_cycles", n), mcyc, e_mcyc);
            chk($sformatf("rand%0d_rdata", n), rd, e_rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
